// File: rtl/atm_keypad_entry_if.sv
// ----------------------------------------------------------------------------
// atm_keypad_entry_if
//   Request/response channel between the ATM keypad front end and the
//   account controller.
//
//   Signals
//     req_valid   : request valid (driven by the front end)
//     req_ready   : controller accepts the request this cycle
//     req_pin     : binary PIN 0..9999, stable while req_valid is high
//     req_amount  : binary amount 0..255, stable while req_valid is high
//     rsp_valid   : one-cycle response strobe from the controller
//     rsp_status  : 00 ok, 01 bad PIN, 10 insufficient funds, 11 locked
//     rsp_balance : balance after the transaction
//
//   Modports
//     master : keypad front end (atm_keypad_entry)
//     slave  : account controller
// ----------------------------------------------------------------------------
interface atm_keypad_entry_if;
    logic        req_valid;
    logic        req_ready;
    logic [13:0] req_pin;
    logic [7:0]  req_amount;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic [7:0]  rsp_balance;

    modport master (
        output req_valid, req_pin, req_amount,
        input  req_ready, rsp_valid, rsp_status, rsp_balance
    );

    modport slave (
        input  req_valid, req_pin, req_amount,
        output req_ready, rsp_valid, rsp_status, rsp_balance
    );
endinterface

// File: rtl/atm_keypad_entry.sv
// ----------------------------------------------------------------------------
// atm_keypad_entry
//   Customer-side front end of the ATM transaction path. Collects keypad
//   digits serially, assembles a 4-digit PIN and a 0..255 withdrawal amount,
//   issues one request per session to the account controller and reports the
//   controller's answer.
//
//   Parameters
//     TIMEOUT_CYCLES : inactivity cycles before a session is abandoned (2..65535)
//     MAX_TRIES      : bad-PIN answers tolerated before local lockout (1..3)
//
//   Ports
//     clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//     face         : customer present (level)
//     key_valid    : one-cycle key strobe, key_code valid this cycle
//     key_code     : 0-9 digit, A CLEAR, B ENTER, C CANCEL, D-F ignored
//     ctrl         : request/response channel (master modport)
//     busy         : high whenever the FSM is not IDLE
//     digit_count  : digits held in the field being entered (0..4)
//     txn_ok       : one-cycle pulse on a successful transaction
//     txn_err      : one-cycle pulse on any error, err_code valid with it
//     err_code     : response status, or 00 for an amount-range error
//     balance_out  : balance captured on the last response
//     timeout      : one-cycle pulse on inactivity abort
//
//   Optional feature (compile-time macro ATM_LOCAL_LOCK_EN)
//     Defined   : consecutive bad-PIN answers are counted; reaching MAX_TRIES
//                 parks the FSM in LOCKOUT (err_code 11) until reset.
//     Undefined : bad-PIN answers simply return to IDLE.
// ----------------------------------------------------------------------------
module atm_keypad_entry #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MAX_TRIES      = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      face,
    input  logic                      key_valid,
    input  logic [3:0]                key_code,
    atm_keypad_entry_if.master        ctrl,
    output logic                      busy,
    output logic [2:0]                digit_count,
    output logic                      txn_ok,
    output logic                      txn_err,
    output logic [1:0]                err_code,
    output logic [7:0]                balance_out,
    output logic                      timeout
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("atm_keypad_entry: TIMEOUT_CYCLES must be in 2..65535");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 3) begin : g_bad_max_tries
        $error("atm_keypad_entry: MAX_TRIES must be in 1..3");
    end

`ifdef ATM_LOCAL_LOCK_EN
    typedef enum logic [2:0] {
        IDLE, PIN_ENTRY, AMT_ENTRY, REQ, WAIT_RSP, LOCKOUT
    } state_t;
    localparam logic [1:0] LOCK_LIMIT = 2'(MAX_TRIES);
    logic [1:0] bad_tries;
`else
    typedef enum logic [2:0] {
        IDLE, PIN_ENTRY, AMT_ENTRY, REQ, WAIT_RSP
    } state_t;
`endif

    localparam logic [3:0]  KEY_CLEAR  = 4'hA;
    localparam logic [3:0]  KEY_ENTER  = 4'hB;
    localparam logic [3:0]  KEY_CANCEL = 4'hC;
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [13:0] pin;
    logic [9:0]  amt;     // 10 bits so a 3-digit entry up to 999 can be range-checked
    logic [15:0] timer;
    logic        is_digit;

    assign is_digit = (key_code <= 4'd9);

    // NOTE: every register here is state, so all updates use non-blocking
    // assignments; blocking ones would make later reads in this block see
    // the new value and the order of statements would change the hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            pin             <= '0;
            amt             <= '0;
            timer           <= '0;
            digit_count     <= '0;
            busy            <= 1'b0;
            txn_ok          <= 1'b0;
            txn_err         <= 1'b0;
            err_code        <= '0;
            balance_out     <= '0;
            timeout         <= 1'b0;
            ctrl.req_valid  <= 1'b0;
            ctrl.req_pin    <= '0;
            ctrl.req_amount <= '0;
`ifdef ATM_LOCAL_LOCK_EN
            bad_tries       <= '0;
`endif
        end else begin
            // Pulse outputs default low; a branch below raises them for one cycle.
            txn_ok  <= 1'b0;
            txn_err <= 1'b0;
            timeout <= 1'b0;

            case (state)
                IDLE: begin
                    timer <= '0;
                    if (face) begin
                        state       <= PIN_ENTRY;
                        busy        <= 1'b1;
                        pin         <= '0;
                        amt         <= '0;
                        digit_count <= '0;
                    end
                end

                PIN_ENTRY, AMT_ENTRY: begin
                    if (!face || (key_valid && key_code == KEY_CANCEL)) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        digit_count <= '0;
                        timer       <= '0;
                    end else if (key_valid) begin
                        // Any key, even an ignored one, counts as activity.
                        timer <= '0;
                        if (is_digit) begin
                            if (state == PIN_ENTRY && digit_count < 3'd4) begin
                                pin         <= pin * 14'd10 + 14'(key_code);
                                digit_count <= digit_count + 3'd1;
                            end else if (state == AMT_ENTRY && digit_count < 3'd3) begin
                                amt         <= amt * 10'd10 + 10'(key_code);
                                digit_count <= digit_count + 3'd1;
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            digit_count <= '0;
                            if (state == PIN_ENTRY) pin <= '0;
                            else                    amt <= '0;
                        end else if (key_code == KEY_ENTER) begin
                            if (state == PIN_ENTRY) begin
                                if (digit_count == 3'd4) begin
                                    state       <= AMT_ENTRY;
                                    digit_count <= '0;
                                end
                            end else if (digit_count != 3'd0) begin
                                if (amt > 10'd255) begin
                                    // Out-of-range amount: report and let the
                                    // customer retype without losing the PIN.
                                    txn_err     <= 1'b1;
                                    err_code    <= 2'b00;
                                    amt         <= '0;
                                    digit_count <= '0;
                                end else begin
                                    state           <= REQ;
                                    digit_count     <= '0;
                                    ctrl.req_valid  <= 1'b1;
                                    ctrl.req_pin    <= pin;
                                    ctrl.req_amount <= amt[7:0];
                                end
                            end
                        end
                    end else if (timer == TIMER_LAST) begin
                        timeout     <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                        digit_count <= '0;
                        timer       <= '0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

                REQ: begin
                    // Controller latency is unbounded, so no timer here;
                    // keys, face and responses are all ignored.
                    timer <= '0;
                    if (ctrl.req_ready) begin
                        state          <= WAIT_RSP;
                        ctrl.req_valid <= 1'b0;
                    end
                end

                WAIT_RSP: begin
                    if (ctrl.rsp_valid) begin
                        balance_out <= ctrl.rsp_balance;
                        timer       <= '0;
                        state       <= IDLE;
                        busy        <= 1'b0;
                        if (ctrl.rsp_status == 2'b00) begin
                            txn_ok <= 1'b1;
                        end else begin
                            txn_err  <= 1'b1;
                            err_code <= ctrl.rsp_status;
                        end
`ifdef ATM_LOCAL_LOCK_EN
                        if (ctrl.rsp_status == 2'b00) begin
                            bad_tries <= '0;
                        end else if (ctrl.rsp_status == 2'b01) begin
                            bad_tries <= bad_tries + 2'd1;
                            if (bad_tries + 2'd1 == LOCK_LIMIT) begin
                                state    <= LOCKOUT;
                                busy     <= 1'b1;
                                err_code <= 2'b11;
                            end
                        end
`endif
                    end else if (key_valid) begin
                        timer <= '0;
                    end else if (timer == TIMER_LAST) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        timer   <= '0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

`ifdef ATM_LOCAL_LOCK_EN
                LOCKOUT: begin
                    // Terminal until reset: keys and face have no effect.
                    timer <= '0;
                end
`endif

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_keypad_entry.sv
// ----------------------------------------------------------------------------
// tb_atm_keypad_entry
//   Self-checking bench for atm_keypad_entry. Directed scenarios plus a
//   randomized session loop checked against a queue-based model of the
//   keypad rules. Build with ATM_LOCAL_LOCK_EN to also exercise lockout.
// ----------------------------------------------------------------------------
module tb_atm_keypad_entry;
    localparam int TO = 8;
`ifdef ATM_LOCAL_LOCK_EN
    localparam bit LOCK_BUILD = 1'b1;
`else
    localparam bit LOCK_BUILD = 1'b0;
`endif

    localparam int PH_IDLE = 0, PH_PIN = 1, PH_AMT = 2, PH_REQ = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       face = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       busy, txn_ok, txn_err, timeout;
    logic [2:0] digit_count;
    logic [1:0] err_code;
    logic [7:0] balance_out;

    int checks = 0;
    int errors = 0;
    int exp_balance = 0;

    // Model of the keypad rules: one queue of typed digits per field.
    int m_pin[$];
    int m_amt[$];
    int m_phase = PH_IDLE;

    atm_keypad_entry_if bus ();

    atm_keypad_entry #(.TIMEOUT_CYCLES(TO), .MAX_TRIES(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .face       (face),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .ctrl       (bus),
        .busy       (busy),
        .digit_count(digit_count),
        .txn_ok     (txn_ok),
        .txn_err    (txn_err),
        .err_code   (err_code),
        .balance_out(balance_out),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

    function automatic int decimal(input int q[$]);
        int v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v;
    endfunction

    task automatic model_key(input int code, output bit range_err);
        range_err = 1'b0;
        if (code <= 9) begin
            if (m_phase == PH_PIN && m_pin.size() < 4) m_pin.push_back(code);
            else if (m_phase == PH_AMT && m_amt.size() < 3) m_amt.push_back(code);
        end else if (code == 10) begin
            if (m_phase == PH_PIN) m_pin.delete();
            else m_amt.delete();
        end else if (code == 11) begin
            if (m_phase == PH_PIN && m_pin.size() == 4) begin
                m_phase = PH_AMT;
            end else if (m_phase == PH_AMT && m_amt.size() > 0) begin
                if (decimal(m_amt) > 255) begin
                    range_err = 1'b1;
                    m_amt.delete();
                end else begin
                    m_phase = PH_REQ;
                end
            end
        end else if (code == 12) begin
            m_phase = PH_IDLE;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        face = 1'b0;
        key_valid = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_balance = 0;
    endtask

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code = code;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code = 4'h0;
    endtask

    task automatic type_number(input int value, input int ndigits);
        int div = 1;
        for (int i = 1; i < ndigits; i++) div = div * 10;
        for (int i = 0; i < ndigits; i++) begin
            press(4'((value / div) % 10));
            div = div / 10;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input string name);
        @(negedge clk);
        face = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || digit_count !== 3'd0)
            $display("FAIL %s_start busy=%b dc=%0d want busy=1 dc=0", name, busy, digit_count);
        if (busy !== 1'b1 || digit_count !== 3'd0) errors++;
    endtask

    task automatic handshake();
        @(negedge clk);
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
    endtask

    task automatic respond(input logic [1:0] st, input logic [7:0] bal);
        @(negedge clk);
        bus.rsp_valid = 1'b1;
        bus.rsp_status = st;
        bus.rsp_balance = bal;
        tick();
        bus.rsp_valid = 1'b0;
    endtask

    // Request check, handshake and response check for a session sitting in REQ.
    task automatic finish_txn(input string name, input int exp_pin, input int exp_amt,
                              input logic [1:0] st, input logic [7:0] bal,
                              input logic [1:0] exp_code, input bit exp_busy);
        checks++;
        if (bus.req_valid !== 1'b1 || bus.req_pin !== 14'(exp_pin) || bus.req_amount !== 8'(exp_amt)) begin
            errors++;
            $display("FAIL %s_req valid=%b pin=%0d amt=%0d want valid=1 pin=%0d amt=%0d",
                     name, bus.req_valid, bus.req_pin, bus.req_amount, exp_pin, exp_amt);
        end
        handshake();
        checks++;
        if (bus.req_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_handshake valid=%b busy=%b want valid=0 busy=1", name, bus.req_valid, busy);
        end
        respond(st, bal);
        exp_balance = bal;
        checks++;
        if (txn_ok !== (st == 2'b00) || txn_err !== (st != 2'b00) || balance_out !== bal ||
            busy !== exp_busy || (st != 2'b00 && err_code !== exp_code)) begin
            errors++;
            $display("FAIL %s_rsp ok=%b err=%b code=%0d bal=%0d busy=%b want ok=%b err=%b code=%0d bal=%0d busy=%b",
                     name, txn_ok, txn_err, err_code, balance_out, busy,
                     st == 2'b00, st != 2'b00, exp_code, bal, exp_busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        face = 1'b1;
        #1;
        checks++;
        if ({busy, digit_count, txn_ok, txn_err, err_code, balance_out, timeout,
             bus.req_valid, bus.req_pin, bus.req_amount} !== 40'h0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b dc=%0d req_valid=%b bal=%0d want all zero",
                     busy, digit_count, bus.req_valid, balance_out);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold busy=%b want 0", busy);
        end
        do_reset();
    endtask

    task automatic test_basic();
        start_session("basic");
        type_number(1234, 4);
        checks++;
        if (digit_count !== 3'd4) begin
            errors++;
            $display("FAIL basic_pin_count got %0d want 4", digit_count);
        end
        press(4'hB);
        type_number(50, 2);
        checks++;
        if (digit_count !== 3'd2 || bus.req_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_amt_count dc=%0d valid=%b want dc=2 valid=0", digit_count, bus.req_valid);
        end
        press(4'hB);
        finish_txn("basic", 1234, 50, 2'b00, 8'd200, 2'b00, 1'b0);
        face = 1'b0;
    endtask

    task automatic test_pin_rules();
        start_session("pin");
        press(4'd1); press(4'd2); press(4'hB);
        checks++;
        if (digit_count !== 3'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pin_short_enter dc=%0d busy=%b want dc=2 busy=1", digit_count, busy);
        end
        press(4'd3); press(4'd4); press(4'd5);
        checks++;
        if (digit_count !== 3'd4) begin
            errors++;
            $display("FAIL pin_fifth_digit got %0d want 4", digit_count);
        end
        press(4'hB);
        press(4'd7); press(4'hB);
        finish_txn("pin", 1234, 7, 2'b10, 8'd33, 2'b10, 1'b0);
        face = 1'b0;
    endtask

    task automatic test_amount_range();
        start_session("amt");
        type_number(1111, 4); press(4'hB);
        type_number(300, 3); press(4'd7);
        checks++;
        if (digit_count !== 3'd3) begin
            errors++;
            $display("FAIL amt_fourth_digit got %0d want 3", digit_count);
        end
        press(4'hB);
        checks++;
        if (txn_err !== 1'b1 || err_code !== 2'b00 || busy !== 1'b1 || digit_count !== 3'd0 || bus.req_valid !== 1'b0) begin
            errors++;
            $display("FAIL amt_range err=%b code=%0d busy=%b dc=%0d valid=%b want 1 0 1 0 0",
                     txn_err, err_code, busy, digit_count, bus.req_valid);
        end
        type_number(255, 3); press(4'hB);
        finish_txn("amt", 1111, 255, 2'b00, 8'd90, 2'b00, 1'b0);
        face = 1'b0;
    endtask

    task automatic test_req_stall();
        start_session("stall");
        type_number(4321, 4); press(4'hB); press(4'd9); press(4'hB);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) face = 1'b0;
            if (i == 10) press(4'hC);
            else if (i == 14) respond(2'b00, 8'd1);
            else tick();
            checks++;
            if (bus.req_valid !== 1'b1 || bus.req_pin !== 14'd4321 || bus.req_amount !== 8'd9 ||
                timeout !== 1'b0 || txn_ok !== 1'b0 || busy !== 1'b1 || balance_out !== 8'(exp_balance)) begin
                errors++;
                $display("FAIL stall_cycle%0d valid=%b pin=%0d amt=%0d to=%b ok=%b bal=%0d want 1 4321 9 0 0 %0d",
                         i, bus.req_valid, bus.req_pin, bus.req_amount, timeout, txn_ok, balance_out, exp_balance);
            end
        end
        finish_txn("stall", 4321, 9, 2'b10, 8'd77, 2'b10, 1'b0);
    endtask

    task automatic test_timeout();
        start_session("tmo_pin");
        press(4'd1); press(4'd2);
        for (int i = 1; i < TO; i++) begin
            tick();
            checks++;
            if (timeout !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL tmo_pin_early%0d to=%b busy=%b want 0 1", i, timeout, busy);
            end
        end
        tick();
        face = 1'b0;
        checks++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_pin_fire to=%b busy=%b want 1 0", timeout, busy);
        end

        start_session("tmo_wait");
        type_number(2222, 4); press(4'hB); press(4'd3); press(4'hB);
        handshake();
        for (int i = 1; i < TO; i++) begin
            tick();
            checks++;
            if (timeout !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL tmo_wait_early%0d to=%b busy=%b want 0 1", i, timeout, busy);
            end
        end
        tick();
        face = 1'b0;
        checks++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_wait_fire to=%b busy=%b want 1 0", timeout, busy);
        end
        respond(2'b00, 8'd250);
        checks++;
        if (txn_ok !== 1'b0 || balance_out !== 8'(exp_balance)) begin
            errors++;
            $display("FAIL idle_rsp_drop ok=%b bal=%0d want 0 %0d", txn_ok, balance_out, exp_balance);
        end
    endtask

    task automatic test_abort();
        start_session("face");
        press(4'd1); press(4'd2);
        @(negedge clk);
        face = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || digit_count !== 3'd0) begin
            errors++;
            $display("FAIL face_drop busy=%b dc=%0d want 0 0", busy, digit_count);
        end
        start_session("cancel");
        type_number(5555, 4); press(4'hB); press(4'd4); press(4'hC);
        face = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.req_valid !== 1'b0) begin
            errors++;
            $display("FAIL cancel_amt busy=%b valid=%b want 0 0", busy, bus.req_valid);
        end
    endtask

    task automatic test_back_to_back();
        start_session("b2b");
        type_number(9999, 4); press(4'hB); press(4'd1); press(4'd2); press(4'hB);
        finish_txn("b2b_first", 9999, 12, 2'b00, 8'd5, 2'b00, 1'b0);
        tick();
        checks++;
        if (busy !== 1'b1 || digit_count !== 3'd0) begin
            errors++;
            $display("FAIL b2b_restart busy=%b dc=%0d want 1 0", busy, digit_count);
        end
        type_number(0, 4); press(4'hB); press(4'hB);
        checks++;
        if (bus.req_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_empty_enter valid=%b busy=%b want 0 1", bus.req_valid, busy);
        end
        press(4'd0); press(4'hB);
        finish_txn("b2b_second", 0, 0, 2'b11, 8'd0, 2'b11, 1'b0);
        face = 1'b0;
    endtask

    task automatic test_async_reset();
        start_session("arst");
        type_number(6789, 4); press(4'hB); type_number(120, 3); press(4'hB);
        handshake();
        respond(2'b00, 8'd99);
        @(negedge clk);
        face = 1'b1;
        tick();
        type_number(1357, 4); press(4'hB); press(4'd8); press(4'hB);
        handshake();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, digit_count, txn_ok, txn_err, err_code, balance_out, timeout,
             bus.req_valid, bus.req_pin, bus.req_amount} !== 40'h0) begin
            errors++;
            $display("FAIL arst_outputs busy=%b bal=%0d pin=%0d want all zero", busy, balance_out, bus.req_pin);
        end
        do_reset();
    endtask

    function automatic int random_code();
        int r = int'($urandom_range(0, 19));
        if (r < 12) return r % 10;
        if (r < 14) return 10;
        if (r < 17) return 11;
        if (r == 17) return ($urandom_range(0, 3) == 0) ? 12 : 11;
        return 13 + int'($urandom_range(0, 2));
    endfunction

    function automatic int completion_code();
        if (m_phase == PH_PIN) return (m_pin.size() < 4) ? int'($urandom_range(0, 9)) : 11;
        return (m_amt.size() == 0) ? int'($urandom_range(0, 9)) : 11;
    endfunction

    task automatic test_random();
        bit e;
        bit lock;
        int code;
        int bad = 0;
        logic [1:0] st;
        logic [7:0] bal;
        do_reset();
        for (int s = 0; s < 40; s++) begin
            start_session("rand");
            m_pin.delete();
            m_amt.delete();
            m_phase = PH_PIN;
            for (int k = 0; k < 80 && (m_phase == PH_PIN || m_phase == PH_AMT); k++) begin
                code = (k < 25) ? random_code() : completion_code();
                repeat ($urandom_range(0, 2)) @(posedge clk);
                press(4'(code));
                model_key(code, e);
                if (m_phase == PH_IDLE) face = 1'b0;
                checks++;
                if (txn_err !== e || (e && err_code !== 2'b00) || busy !== (m_phase != PH_IDLE) ||
                    bus.req_valid !== (m_phase == PH_REQ)) begin
                    errors++;
                    $display("FAIL rand_key s%0d k%0d code=%0d err=%b busy=%b valid=%b want err=%b busy=%b valid=%b",
                             s, k, code, txn_err, busy, bus.req_valid, e, m_phase != PH_IDLE, m_phase == PH_REQ);
                end
                if (m_phase == PH_PIN || m_phase == PH_AMT) begin
                    checks++;
                    if (digit_count !== 3'((m_phase == PH_PIN) ? m_pin.size() : m_amt.size())) begin
                        errors++;
                        $display("FAIL rand_count s%0d k%0d got %0d want %0d", s, k, digit_count,
                                 (m_phase == PH_PIN) ? m_pin.size() : m_amt.size());
                    end
                end
            end
            if (m_phase == PH_PIN || m_phase == PH_AMT) begin
                checks++;
                errors++;
                $display("FAIL rand_session s%0d got unfinished want request", s);
                face = 1'b0;
            end
            if (m_phase == PH_REQ) begin
                repeat ($urandom_range(0, 3)) tick();
                st = 2'($urandom_range(0, 3));
                bal = 8'($urandom_range(0, 255));
                lock = 1'b0;
                if (st == 2'b00) bad = 0;
                if (st == 2'b01) begin
                    bad++;
                    lock = LOCK_BUILD && (bad == 3);
                end
                finish_txn("rand", decimal(m_pin), decimal(m_amt), st, bal,
                           lock ? 2'b11 : st, lock);
                face = 1'b0;
                if (lock) begin
                    do_reset();
                    bad = 0;
                end
            end
        end
    endtask

`ifdef ATM_LOCAL_LOCK_EN
    task automatic test_lockout();
        do_reset();
        for (int t = 1; t <= 3; t++) begin
            start_session("lock");
            type_number(1111, 4); press(4'hB); press(4'd1); press(4'hB);
            finish_txn("lock", 1111, 1, 2'b01, 8'(t), (t == 3) ? 2'b11 : 2'b01, t == 3);
            if (t < 3) face = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            face = (i % 3) != 0;
            press(4'(int'($urandom_range(0, 15))));
            checks++;
            if (busy !== 1'b1 || bus.req_valid !== 1'b0 || digit_count !== 3'd0 || txn_ok !== 1'b0) begin
                errors++;
                $display("FAIL lock_hold%0d busy=%b valid=%b dc=%0d want 1 0 0", i, busy, bus.req_valid, digit_count);
            end
        end
        do_reset();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL lock_reset busy=%b want 0", busy);
        end
    endtask
`endif

    initial begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_status = 2'b00;
        bus.rsp_balance = 8'h00;
        test_reset();
        test_basic();
        test_pin_rules();
        test_amount_range();
        test_req_stall();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_random();
`ifdef ATM_LOCAL_LOCK_EN
        test_lockout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/atm_keypad_entry.md
Name: atm_keypad_entry

Overview:
Customer-side front end of the ATM transaction interface. It collects keypad digits serially, assembles a 4-digit PIN and a withdrawal amount, and issues one request per session to the account controller over a valid/ready handshake. It then waits for the controller's response and reports the result and balance. It sits between the keypad/face-detect inputs and the account controller.

Parameters:
TIMEOUT_CYCLES, 1000, inactivity cycles before the session is abandoned (valid range 2..65535)
MAX_TRIES, 3, bad-PIN responses tolerated before local lockout (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
face  in  1  customer present; level, gates session start and continuation
key_valid  in  1  one-cycle strobe; key_code is valid this cycle
key_code  in  4  0-9 digit, 0xA CLEAR, 0xB ENTER, 0xC CANCEL, 0xD-0xF ignored
req_valid  out  1  request valid
req_ready  in  1  controller accepts request
req_pin  out  14  binary PIN value 0..9999
req_amount  out  8  binary amount 0..255
rsp_valid  in  1  one-cycle response strobe
rsp_status  in  2  00 ok, 01 bad PIN, 10 insufficient funds, 11 account locked
rsp_balance  in  8  balance after the transaction
busy  out  1  high in any state other than IDLE
digit_count  out  3  digits held in the current field (0..4)
txn_ok  out  1  one-cycle pulse when the transaction succeeds
txn_err  out  1  one-cycle pulse on any error
err_code  out  2  captured with txn_err: rsp_status, or 00 for an amount-range error
balance_out  out  8  rsp_balance captured on the response; held until the next response
timeout  out  1  one-cycle pulse on inactivity abort

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; internal PIN, amount, digit and timer registers 0.
- States: IDLE, PIN_ENTRY, AMT_ENTRY, REQ, WAIT_RSP, LOCKOUT (LOCKOUT only with the optional feature).
- IDLE: face=1 moves to PIN_ENTRY on the next cycle and clears the buffers. Keys are ignored in IDLE.
- PIN_ENTRY digit key: pin <= pin*10 + d and digit_count++. A digit arriving when digit_count=4 is ignored.
- PIN_ENTRY ENTER: accepted only when digit_count=4; the FSM moves to AMT_ENTRY and digit_count returns to 0. ENTER is ignored when fewer than 4 digits are held.
- AMT_ENTRY: up to 3 digits, accumulated in a 10-bit register as amt*10 + d. A 4th digit is ignored.
- AMT_ENTRY ENTER with 0 digits: ignored.
- AMT_ENTRY ENTER with value >255: pulse txn_err with err_code=00, clear the amount, stay in AMT_ENTRY.
- AMT_ENTRY ENTER with value <=255: move to REQ.
- CLEAR zeroes the current field and digit_count. CANCEL, or face falling to 0, in PIN_ENTRY or AMT_ENTRY returns to IDLE. Both are ignored in REQ and WAIT_RSP.
- REQ: req_valid=1. req_pin and req_amount stay stable until the cycle where req_valid & req_ready; that cycle the FSM moves to WAIT_RSP and req_valid drops the next cycle. Transaction latency is unbounded.
- WAIT_RSP: rsp_valid is sampled only in this state. On rsp_valid, capture balance_out. Status 00 pulses txn_ok; any other status pulses txn_err with err_code=rsp_status. The FSM then returns to IDLE.
- A rsp_valid arriving during REQ or IDLE is dropped.
- Timer: cleared on any key_valid and on every state change. It counts in PIN_ENTRY, AMT_ENTRY and WAIT_RSP. When it reaches TIMEOUT_CYCLES-1, pulse timeout and go to IDLE. It does not run in REQ.
- Back-to-back sessions: a new session needs face=1 in IDLE, so there is at least one idle cycle between sessions.

Optional Feature:
ATM_LOCAL_LOCK_EN
- Defined: a 2-bit counter increments on every rsp_status=01. At MAX_TRIES the FSM enters LOCKOUT instead of IDLE and pulses txn_err with err_code=11. LOCKOUT ignores all keys and face; only rst_n leaves it. The counter clears on rsp_status=00.
- Undefined: no counter and no LOCKOUT state; bad-PIN responses always return to IDLE.

Test Plan:
- face=1, keys 1,2,3,4,ENTER,5,0,ENTER; req_ready=1 -> req_pin=1234 and req_amount=50 at handshake. Then rsp_valid, status 00, balance 200 -> txn_ok pulse, balance_out=200, state IDLE.
- Keys 1,2,ENTER -> ENTER ignored, digit_count=2. Then 3,4,5,ENTER -> digit 5 ignored, PIN 1234 accepted.
- Amount keys 3,0,0,ENTER -> txn_err with err_code=00, still in AMT_ENTRY. Then 2,5,5,ENTER -> req_amount=255.
- req_ready held 0 for 20 cycles -> req_valid high and outputs stable, no timeout. A CANCEL in this window is ignored.
- With TIMEOUT_CYCLES=8, idle for 8 cycles in PIN_ENTRY after 2 digits -> timeout pulse, state IDLE. rst_n asserted mid-WAIT_RSP -> all outputs 0 immediately.
- With ATM_LOCAL_LOCK_EN and MAX_TRIES=3: three sessions each answered with status 01 -> third gives txn_err with err_code=11, busy stays 1, keys ignored until reset.
